crc_req_scheduler: RTL and testbench
====================================

Name: crc_req_scheduler

Overview:
Round-robin scheduler that shares one byte-serial CRC engine between two frame requesters. It grants one requester per frame and pulses a clear to the engine before the frame. It streams the requester's bytes and last flag into the engine, waits for the engine's result, and returns the CRC or a timeout error to the granted requester. It sits between the packet sources and the CRC engine's crc/last/crc_output interface.

Parameters:
DATA_W, 8, byte width of data and CRC result
TIMEOUT, 64, max cycles in WAIT for crc_done before error; 1..255

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has a byte on req0_data
req0_data  in  DATA_W  requester 0 byte
req0_last  in  1  byte is final byte of frame
req0_ready  out  1  byte accepted when req0_valid & req0_ready
res0_valid  out  1  one-cycle result pulse to requester 0
res0_crc  out  DATA_W  CRC result, held until next res0_valid
res0_err  out  1  timeout flag, qualified by res0_valid
req1_valid, req1_data, req1_last, req1_ready, res1_valid, res1_crc, res1_err: same as requester 0, for requester 1
crc_start  out  1  one-cycle engine clear before first byte
crc_data  out  DATA_W  byte to engine
crc_valid  out  1  crc_data valid this cycle
crc_last  out  1  qualifies final byte, only with crc_valid
crc_in  in  DATA_W  engine result
crc_done  in  1  engine result valid, one-cycle pulse
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, grant=0, rr_ptr=0, timeout counter=0. All outputs 0, including res*_crc and res*_err.
- FSM: IDLE -> START -> STREAM -> WAIT -> RESP -> IDLE.
- IDLE:
  - Any reqX_valid selects a winner.
  - If both are valid, the winner is rr_ptr (0 or 1). If one is valid, that one wins regardless of rr_ptr.
  - Latch grant = winner; go to START. reqX_ready=0 in IDLE; no byte is consumed.
- START: crc_start=1 for exactly one cycle, then STREAM.
- STREAM:
  - req_ready of the granted requester = 1; the other requester's ready = 0.
  - crc_data/crc_valid/crc_last are combinational pass-through of the granted requester's data/valid/last. This gives 0-cycle latency and one byte per cycle at full rate.
  - A byte with last=1 accepted -> WAIT next cycle, with the counter cleared.
  - Bubbles (valid=0) are allowed indefinitely; no timeout applies in STREAM.
- WAIT:
  - The counter increments each cycle.
  - If crc_done=1: latch crc_in into res<grant>_crc, set res<grant>_err=0, go to RESP.
  - Else if counter == TIMEOUT-1: set res<grant>_err=1, leave res<grant>_crc unchanged, go to RESP.
  - If crc_done arrives on the timeout cycle, crc_done wins (err=0).
- RESP:
  - res<grant>_valid=1 for one cycle; rr_ptr = ~grant; go to IDLE.
  - A new frame can be granted on the cycle after RESP; minimum frame spacing is 4 cycles of overhead.
- crc_done outside WAIT is ignored.
- The ungranted requester sees ready=0 and res_valid=0 for the whole frame.
- rr_ptr updates only in RESP. A frame aborted by reset does not advance it.
- Reset asserted mid-frame returns to IDLE immediately with all outputs 0. The engine is re-cleared by crc_start on the next grant.
- A requester may drop valid in IDLE before being granted; no grant occurs if both valid signals are 0.

Test Plan:
1. Reset release, idle check: hold reset=0 for 10 cycles, then 1 with all valids 0 -> busy=0, all outputs 0, no crc_start.
2. Single-byte frame, requester 0:
   - Stimulus: req0 sends 0x68 with last=1. Engine model asserts crc_done with crc_in=0x5A 3 cycles after crc_last.
   - Required: one crc_start pulse, then crc_data=0x68 with crc_valid=1 and crc_last=1 in the cycle after it.
   - Required: res0_valid pulse with res0_crc=0x5A, res0_err=0; res1_* stay 0.
3. Multi-byte frame with bubble, requester 1:
   - Stimulus: bytes 0x01, (valid=0 for 2 cycles), 0x02, 0x03 last.
   - Required: crc_valid pattern 1,0,0,1,1; crc_last only on 0x03; req0_ready=0 throughout; res1_valid pulses once.
4. Simultaneous requests after reset, both reqX_valid=1:
   - Required: requester 0 is served first, then requester 1, then requester 0 again if both stay valid; grants alternate.
5. Timeout, TIMEOUT=64:
   - Stimulus: engine model never asserts crc_done.
   - Required: exactly 64 WAIT cycles, then resX_valid with resX_err=1, resX_crc unchanged; the next frame proceeds normally.
6. Reset mid-STREAM:
   - Stimulus: pull reset low after the 2nd byte.
   - Required: outputs go 0 asynchronously and busy=0; after release, a new frame gets a fresh crc_start; rr_ptr is unchanged.

Source files
------------

// File: rtl/crc_req_scheduler.sv
// Round-robin scheduler sharing one byte-serial CRC engine between two frame
// requesters: grant, engine clear, byte streaming, result/timeout return.
module crc_req_scheduler #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  output logic              res0_valid,
  output logic [DATA_W-1:0] res0_crc,
  output logic              res0_err,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              res1_valid,
  output logic [DATA_W-1:0] res1_crc,
  output logic              res1_err,
  output logic              crc_start,
  output logic [DATA_W-1:0] crc_data,
  output logic              crc_valid,
  output logic              crc_last,
  input  logic [DATA_W-1:0] crc_in,
  input  logic              crc_done,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, START, STREAM, WAIT, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] res0_crc_q, res0_crc_d;
  logic [DATA_W-1:0] res1_crc_q, res1_crc_d;
  logic              res0_err_q, res0_err_d;
  logic              res1_err_q, res1_err_d;

  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;

  assign sel_valid = grant_q ? req1_valid : req0_valid;
  assign sel_data  = grant_q ? req1_data  : req0_data;
  assign sel_last  = grant_q ? req1_last  : req0_last;

  assign res0_crc = res0_crc_q;
  assign res1_crc = res1_crc_q;
  assign res0_err = res0_err_q;
  assign res1_err = res1_err_q;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    res0_crc_d = res0_crc_q;
    res1_crc_d = res1_crc_q;
    res0_err_d = res0_err_q;
    res1_err_d = res1_err_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    res0_valid = 1'b0;
    res1_valid = 1'b0;
    crc_start  = 1'b0;
    crc_data   = '0;
    crc_valid  = 1'b0;
    crc_last   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // rr_ptr only breaks ties; a lone requester always wins
        if (req0_valid || req1_valid) begin
          grant_d = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
          state_d = START;
        end
      end
      START: begin
        crc_start = 1'b1;
        state_d   = STREAM;
      end
      STREAM: begin
        req0_ready = ~grant_q;
        req1_ready = grant_q;
        crc_valid  = sel_valid;
        crc_data   = sel_data;
        crc_last   = sel_valid & sel_last;
        if (sel_valid && sel_last) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // a result arriving on the final timeout cycle still counts as success
        if (crc_done) begin
          if (grant_q) begin
            res1_crc_d = crc_in;
            res1_err_d = 1'b0;
          end else begin
            res0_crc_d = crc_in;
            res0_err_d = 1'b0;
          end
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          if (grant_q) res1_err_d = 1'b1;
          else         res0_err_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        res0_valid = ~grant_q;
        res1_valid = grant_q;
        rr_ptr_d   = ~grant_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      rr_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      res0_crc_q <= '0;
      res1_crc_q <= '0;
      res0_err_q <= 1'b0;
      res1_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      res0_crc_q <= res0_crc_d;
      res1_crc_q <= res1_crc_d;
      res0_err_q <= res0_err_d;
      res1_err_q <= res1_err_d;
    end
  end

endmodule

// File: tb/tb_crc_req_scheduler.sv
// Bench for crc_req_scheduler: requester BFMs, CRC-8 engine model and a
// frame-level scoreboard predicting every output each cycle.
module tb_crc_req_scheduler;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid, req0_last, req0_ready, res0_valid, res0_err;
  logic          req1_valid, req1_last, req1_ready, res1_valid, res1_err;
  logic [DW-1:0] req0_data, req1_data, res0_crc, res1_crc;
  logic          crc_start, crc_valid, crc_last, crc_done, busy;
  logic [DW-1:0] crc_data, crc_in;

  always #5 clock = ~clock;

  crc_req_scheduler #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last),
    .req0_ready(req0_ready), .res0_valid(res0_valid), .res0_crc(res0_crc),
    .res0_err(res0_err),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last),
    .req1_ready(req1_ready), .res1_valid(res1_valid), .res1_crc(res1_crc),
    .res1_err(res1_err),
    .crc_start(crc_start), .crc_data(crc_data), .crc_valid(crc_valid),
    .crc_last(crc_last), .crc_in(crc_in), .crc_done(crc_done), .busy(busy)
  );

  typedef struct { logic [7:0] data; logic last; int unsigned gap; } bfm_byte_t;
  typedef struct { logic [7:0] crc; int unsigned delay; logic fen; logic [7:0] fval; } frame_t;

  bfm_byte_t   bq [2][$];
  frame_t      finfo [2][$];
  int unsigned gap_left [2];
  logic [7:0]  build_crc [2];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          cyc = 0;

  bit         m_free, m_win, m_rr, m_stream, res_to;
  int         start_cyc, resp_cyc;
  frame_t     cur;
  logic [7:0] res_val;
  logic [7:0] e_crc [2];
  logic       e_err [2];

  int unsigned eng_pend;
  logic [7:0]  eng_acc, eng_val;
  bit          spur_en;

  int          srv[$];
  logic [15:0] cv_bits;
  int          cv_len, n_start, last_obs_cyc, res_obs_cyc;
  bit          cv_rec;

  function automatic logic [7:0] crc8_step(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c = c_in ^ d;
    for (int i = 0; i < 8; i++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction

  function automatic int srv_code();
    int code = srv.size() << 8;
    for (int i = 0; i < srv.size() && i < 8; i++) code = code | (srv[i] << i);
    return code;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic last,
                           input int unsigned gap, input int unsigned dly,
                           input logic fen, input logic [7:0] fval);
    bfm_byte_t b;
    frame_t    f;
    if (bq[r].size() == 0) gap_left[r] = gap;
    b.data = d; b.last = last; b.gap = gap;
    bq[r].push_back(b);
    build_crc[r] = crc8_step(build_crc[r], d);
    if (last) begin
      f.crc = build_crc[r]; f.delay = dly; f.fen = fen; f.fval = fval;
      finfo[r].push_back(f);
      build_crc[r] = '0;
    end
  endtask

  task automatic rand_frame(input int r);
    int          len = $urandom_range(1, 5);
    int          sel = $urandom_range(0, 15);
    int unsigned dly;
    logic        fen = ($urandom_range(0, 3) == 0);
    if (sel < 11)       dly = $urandom_range(1, 8);
    else if (sel < 13)  dly = 0;
    else if (sel == 13) dly = TO;
    else                dly = TO + 1 + $urandom_range(0, 1);
    for (int k = 0; k < len; k++)
      push_byte(r, 8'($urandom), k == len - 1, (k == 0) ? 0 : $urandom_range(0, 2),
                dly, fen, 8'($urandom));
  endtask

  task automatic tick();
    logic       pv [2];
    logic       pl [2];
    logic [7:0] pd [2];
    logic       o_busy, o_start, o_cv, o_cl;
    logic       o_r [2];
    logic       o_rv [2];
    logic       o_err [2];
    logic [7:0] o_cd;
    logic [7:0] o_crc [2];
    logic       e_cv, e_cl;
    bit         in_wait;
    for (int r = 0; r < 2; r++) begin
      pv[r] = (bq[r].size() != 0) && (gap_left[r] == 0);
      pd[r] = pv[r] ? bq[r][0].data : 8'($urandom);
      pl[r] = pv[r] ? bq[r][0].last : 1'($urandom);
    end
    req0_valid = pv[0]; req0_data = pd[0]; req0_last = pl[0];
    req1_valid = pv[1]; req1_data = pd[1]; req1_last = pl[1];
    in_wait  = (resp_cyc >= 0) && (cyc < resp_cyc);
    crc_done = 1'b0;
    crc_in   = 8'($urandom);
    if (eng_pend != 0) begin
      eng_pend--;
      if (eng_pend == 0) begin crc_done = 1'b1; crc_in = eng_val; end
    end else if (spur_en && !in_wait && $urandom_range(0, 5) == 0) begin
      crc_done = 1'b1;
    end
    #2;
    o_busy = busy; o_start = crc_start; o_cv = crc_valid; o_cl = crc_last; o_cd = crc_data;
    o_r[0] = req0_ready; o_rv[0] = res0_valid; o_crc[0] = res0_crc; o_err[0] = res0_err;
    o_r[1] = req1_ready; o_rv[1] = res1_valid; o_crc[1] = res1_crc; o_err[1] = res1_err;

    if (cyc == resp_cyc) begin
      if (!res_to) e_crc[m_win] = res_val;
      e_err[m_win] = res_to;
    end
    e_cv = m_stream && pv[m_win];
    e_cl = e_cv && pl[m_win];
    chk("busy", o_busy, !m_free);
    chk("crc_start", o_start, cyc == start_cyc);
    chk("crc_valid", o_cv, e_cv);
    chk("crc_last", o_cl, e_cl);
    if (e_cv) chk("crc_data", o_cd, pd[m_win]);
    chk("req0_ready", o_r[0], m_stream && !m_win);
    chk("req1_ready", o_r[1], m_stream && m_win);
    chk("res0_valid", o_rv[0], cyc == resp_cyc && !m_win);
    chk("res1_valid", o_rv[1], cyc == resp_cyc && m_win);
    chk("res0_crc", o_crc[0], e_crc[0]);
    chk("res1_crc", o_crc[1], e_crc[1]);
    chk("res0_err", o_err[0], e_err[0]);
    chk("res1_err", o_err[1], e_err[1]);

    if (cyc == resp_cyc) begin
      m_rr = !m_win; m_free = 1'b1; resp_cyc = -1;
    end else if (m_free) begin
      if (pv[0] || pv[1]) begin
        m_win = (pv[0] && pv[1]) ? m_rr : pv[1];
        m_free = 1'b0;
        start_cyc = cyc + 1;
        if (finfo[m_win].size() != 0) begin
          cur = finfo[m_win][0];
          finfo[m_win].delete(0);
        end
      end
    end else if (cyc == start_cyc) begin
      m_stream = 1'b1;
    end else if (m_stream && pv[m_win] && pl[m_win]) begin
      m_stream = 1'b0;
      res_to   = (cur.delay == 0) || (cur.delay > TO);
      res_val  = cur.fen ? cur.fval : cur.crc;
      resp_cyc = cyc + (res_to ? int'(TO) + 1 : int'(cur.delay) + 1);
    end

    if (cv_rec) begin
      cv_bits = {cv_bits[14:0], o_cv};
      cv_len++;
      if (o_cv && o_cl) cv_rec = 1'b0;
    end
    if (o_start) begin
      eng_acc = '0; eng_pend = 0; n_start++;
      cv_rec = 1'b1; cv_bits = '0; cv_len = 0;
    end
    if (o_cv) begin
      eng_acc = crc8_step(eng_acc, o_cd);
      if (o_cl) begin
        eng_pend = cur.delay;
        eng_val = cur.fen ? cur.fval : eng_acc;
        last_obs_cyc = cyc;
      end
    end
    for (int r = 0; r < 2; r++) begin
      if (o_rv[r]) begin srv.push_back(r); res_obs_cyc = cyc; end
      if (pv[r] && o_r[r]) begin
        bq[r].delete(0);
        gap_left[r] = (bq[r].size() != 0) ? bq[r][0].gap : 0;
      end else if (bq[r].size() != 0 && gap_left[r] != 0) begin
        gap_left[r]--;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; crc_done = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_crc_start", crc_start, 0);
    chk("rst_crc_valid", crc_valid, 0);
    chk("rst_crc_last", crc_last, 0);
    chk("rst_crc_data", crc_data, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    chk("rst_res_valid", {res1_valid, res0_valid}, 0);
    chk("rst_res0", {res0_err, res0_crc}, 0);
    chk("rst_res1", {res1_err, res1_crc}, 0);
    m_free = 1'b1; m_stream = 1'b0; m_rr = 1'b0; m_win = 1'b0;
    start_cyc = -1; resp_cyc = -1; eng_pend = 0;
    for (int r = 0; r < 2; r++) begin
      e_crc[r] = '0; e_err[r] = 1'b0;
      bq[r].delete(); finfo[r].delete();
      gap_left[r] = 0; build_crc[r] = '0;
    end
    repeat (n) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    cyc += n + 2;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    bit drained;
    do begin
      tick();
      n++;
      drained = m_free && bq[0].size() == 0 && bq[1].size() == 0;
    end while (!drained && n < budget);
    chk("drain_budget", drained, 1);
  endtask

  initial begin
    req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
    crc_done = 1'b0; crc_in = '0;
    spur_en = 1'b0; cv_rec = 1'b0; cv_bits = '0; cv_len = 0; n_start = 0;
    last_obs_cyc = 0; res_obs_cyc = 0;
    #2;
    apply_reset(10);

    // idle after reset, stray crc_done must be ignored
    spur_en = 1'b1;
    repeat (6) tick();
    spur_en = 1'b0;

    // single byte frame from requester 0, engine answers 0x5A three cycles later
    srv.delete();
    push_byte(0, 8'h68, 1'b1, 0, 3, 1'b1, 8'h5A);
    run_until_idle(200);
    chk("t2_served", srv_code(), (1 << 8) | 0);
    chk("t2_cv_pattern", {cv_len[15:0], cv_bits}, {16'd1, 16'h0001});
    chk("t2_last_to_res", res_obs_cyc - last_obs_cyc, 4);

    // requester 1, bubbles inside the frame
    srv.delete();
    push_byte(1, 8'h01, 1'b0, 0, 0, 1'b0, 8'h00);
    push_byte(1, 8'h02, 1'b0, 2, 0, 1'b0, 8'h00);
    push_byte(1, 8'h03, 1'b1, 0, 4, 1'b0, 8'h00);
    run_until_idle(200);
    chk("t3_served", srv_code(), (1 << 8) | 1);
    chk("t3_cv_pattern", {cv_len[15:0], cv_bits}, {16'd5, 16'h0013});

    // simultaneous requests after reset alternate 0,1,0
    apply_reset(3);
    srv.delete();
    push_byte(0, 8'hA1, 1'b0, 0, 0, 1'b0, 8'h00);
    push_byte(0, 8'hA2, 1'b1, 0, 2, 1'b0, 8'h00);
    push_byte(0, 8'hA3, 1'b0, 0, 0, 1'b0, 8'h00);
    push_byte(0, 8'hA4, 1'b1, 0, 2, 1'b0, 8'h00);
    push_byte(1, 8'hB1, 1'b0, 0, 0, 1'b0, 8'h00);
    push_byte(1, 8'hB2, 1'b1, 0, 2, 1'b0, 8'h00);
    run_until_idle(300);
    chk("t4_order", srv_code(), (3 << 8) | 2);

    // timeout, then a normal frame, then done on the final timeout cycle
    srv.delete();
    push_byte(1, 8'h77, 1'b1, 0, 0, 1'b0, 8'h00);
    run_until_idle(300);
    chk("t5_wait_cycles", res_obs_cyc - last_obs_cyc - 1, TO);
    chk("t5_err1", res1_err, 1);
    push_byte(0, 8'h55, 1'b1, 0, 2, 1'b0, 8'h00);
    run_until_idle(300);
    chk("t5_err0", res0_err, 0);
    push_byte(0, 8'h66, 1'b1, 0, TO, 1'b0, 8'h00);
    run_until_idle(300);
    chk("t5_edge_wait", res_obs_cyc - last_obs_cyc - 1, TO);
    chk("t5_served", srv_code(), (3 << 8) | 1);

    // reset in the middle of a stream; rr_ptr left at 0 beforehand
    push_byte(1, 8'h10, 1'b1, 0, 1, 1'b0, 8'h00);
    run_until_idle(200);
    for (int k = 0; k < 5; k++) push_byte(0, 8'(8'h20 + k), k == 4, 0, 2, 1'b0, 8'h00);
    repeat (4) tick();
    apply_reset(2);
    srv.delete();
    n_start = 0;
    push_byte(1, 8'hC1, 1'b1, 0, 3, 1'b0, 8'h00);
    push_byte(0, 8'hC0, 1'b1, 0, 3, 1'b0, 8'h00);
    run_until_idle(200);
    chk("t6_order", srv_code(), (2 << 8) | 2);
    chk("t6_starts", n_start, 2);

    // randomized traffic on both requesters
    spur_en = 1'b1;
    for (int it = 0; it < 40; it++) begin
      int sel = $urandom_range(0, 2);
      if (sel != 1) rand_frame(0);
      if (sel != 0) rand_frame(1);
      if ($urandom_range(0, 1) == 1) rand_frame(0);
      run_until_idle(3000);
    end
    spur_en = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
